// File: rtl/pe_array_pkg.sv
// Shared types and helpers for the PE array feeder and its skew lines.
package pe_array_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    COMPUTE = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  // Cycles needed after the last activation so its deepest lane and the
  // partial sums have drained out of the array.
  function automatic int flush_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // LSB position of element `lane` in a flat lane-packed bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_array_feeder_skew_line.sv
// Per-lane delay line: DEPTH register stages, advancing only when en is high.
module pe_skew_line #(
  parameter int W     = 19,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Lane 0 has no extra delay; control inputs are intentionally unused.
      logic unused_ok;
      assign unused_ok = ^{clk, rst, en};
      assign q = d;
    end else begin : g_dly
      logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

      // Shift one stage per enabled cycle, otherwise hold.
      always_comb begin
        pipe_d = pipe_q;
        if (en) begin
          pipe_d[0] = d;
          for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      // Stage registers with synchronous clear.
      always_ff @(posedge clk) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
      end

      assign q = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pe_array_feeder.sv
// Sequencer feeding a weight tile then skewed activation vectors to PE_array.
module pe_array_feeder
  import pe_array_pkg::*;
#(
  parameter int data_width         = 19,
  parameter int a_tile_row_size    = 4,
  parameter int w_tile_column_size = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [data_width*w_tile_column_size-1:0]   w_data,
  input  logic                                       a_valid,
  output logic                                       a_ready,
  input  logic [data_width*a_tile_row_size-1:0]      a_data,
  input  logic                                       a_last,
  output logic                                       w_en,
  output logic                                       w_compute,
  output logic [data_width*w_tile_column_size-1:0]   in_weight_above,
  output logic [data_width*a_tile_row_size-1:0]      active_left,
  output logic [2*data_width*w_tile_column_size-1:0] in_sum,
  output logic                                       busy,
  output logic                                       done
);

  localparam int DW      = data_width;
  localparam int ROWS    = a_tile_row_size;
  localparam int COLS    = w_tile_column_size;
  localparam int FLUSH_N = flush_cycles(ROWS, COLS);
  localparam int WCW     = cnt_w(ROWS);
  localparam int FCW     = cnt_w(FLUSH_N);

  state_e                  state_q, state_d;
  logic [WCW-1:0]          wcnt_q, wcnt_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  logic                    w_en_q, w_en_d;
  logic [DW*COLS-1:0]      wgt_q, wgt_d;
  logic [ROWS-1:0][DW-1:0] ain_q, ain_d;
  logic [ROWS-1:0][DW-1:0] lane_out;
  logic                    w_hs, a_hs, shift_en;

  assign w_hs = w_valid & w_ready;
  assign a_hs = a_valid & a_ready;

  // State, counters and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      w_en_q  <= 1'b0;
      wgt_q   <= '0;
      ain_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      w_en_q  <= w_en_d;
      wgt_q   <= wgt_d;
      ain_q   <= ain_d;
    end
  end

  // Next state and beat/flush counters.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD_W;
        wcnt_d  = '0;
      end
      LOAD_W: if (w_hs) begin
        if (wcnt_q == WCW'(ROWS - 1)) begin
          state_d = COMPUTE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      COMPUTE: if (a_hs && a_last) begin
        state_d = FLUSH;
        fcnt_d  = '0;
      end
      FLUSH: begin
        if (fcnt_q == FCW'(FLUSH_N - 1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and mode outputs decoded from state only.
  always_comb begin
    w_ready   = 1'b0;
    a_ready   = 1'b0;
    w_compute = 1'b0;
    shift_en  = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    case (state_q)
      LOAD_W:  w_ready = 1'b1;
      COMPUTE: begin
        a_ready   = 1'b1;
        w_compute = 1'b1;
        shift_en  = 1'b1;
      end
      FLUSH: begin
        w_compute = 1'b1;
        shift_en  = 1'b1;
        done      = (fcnt_q == FCW'(FLUSH_N - 1));
      end
      default: ;
    endcase
  end

  // Weight capture and activation input register; non-beats inject zeros.
  always_comb begin
    w_en_d = w_hs;
    wgt_d  = w_hs ? w_data : wgt_q;
    ain_d  = a_hs ? a_data : '0;
  end

  genvar g;
  generate
    for (g = 0; g < ROWS; g++) begin : g_lane
      pe_skew_line #(.W(DW), .DEPTH(g)) u_skew (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .d   (ain_q[g]),
        .q   (lane_out[g])
      );
      assign active_left[lane_lsb(g, DW) +: DW] = lane_out[g];
    end
  endgenerate

  assign w_en            = w_en_q;
  assign in_weight_above = wgt_q;
  assign in_sum          = '0;

endmodule

// File: tb/tb_pe_array_feeder.sv
// Randomized bench for pe_array_feeder against a cycle-history reference model.
module tb_pe_array_feeder;

  localparam int DW   = 19;
  localparam int ROWS = 4;
  localparam int COLS = 2;
  localparam int WW   = DW * COLS;
  localparam int AW   = DW * ROWS;
  localparam int FLN  = ROWS + COLS - 1;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          w_valid = 1'b0, a_valid = 1'b0, a_last = 1'b0;
  logic [WW-1:0] w_data = '0;
  logic [AW-1:0] a_data = '0;
  logic          w_ready, a_ready, w_en, w_compute, busy, done;
  logic [WW-1:0] in_weight_above;
  logic [AW-1:0] active_left;
  logic [2*WW-1:0] in_sum;

  always #5 clk = ~clk;

  pe_array_feeder #(.data_width(DW), .a_tile_row_size(ROWS), .w_tile_column_size(COLS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .w_en(w_en), .w_compute(w_compute), .in_weight_above(in_weight_above),
    .active_left(active_left), .in_sum(in_sum), .busy(busy), .done(done)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading weights, 2 streaming, 3 draining.
  // ring[c] holds the vector that entered the array at the start of cycle c;
  // lane r visible in cycle c is lane r of the vector that entered at c-r.
  int            m_phase = 0, m_beats = 0, m_fl = 0, cyc = 0, wen_cnt = 0;
  logic          m_wen = 1'b0;
  logic [WW-1:0] m_wgt = '0;
  logic [AW-1:0] ring [16];

  initial foreach (ring[i]) ring[i] = '0;

  always @(negedge clk) begin
    logic [AW-1:0] nv, exp_al;
    for (int r = 0; r < ROWS; r++) exp_al[r*DW +: DW] = ring[(cyc - r) & 15][r*DW +: DW];
    chk("w_ready",   w_ready,   m_phase == 1);
    chk("a_ready",   a_ready,   m_phase == 2);
    chk("w_compute", w_compute, m_phase >= 2);
    chk("busy",      busy,      m_phase != 0);
    chk("done",      done,      (m_phase == 3) && (m_fl == FLN - 1));
    chk("w_en",      w_en,      m_wen);
    chk("in_weight", in_weight_above, m_wgt);
    chk("active",    active_left, exp_al);
    chk("in_sum",    in_sum,    '0);
    if (w_en === 1'b1) wen_cnt++;
    if (rst) begin
      m_phase = 0; m_beats = 0; m_fl = 0; m_wen = 1'b0; m_wgt = '0; nv = '0;
      foreach (ring[i]) ring[i] = '0;
    end else begin
      nv    = (m_phase == 2 && a_valid) ? a_data : '0;
      m_wen = (m_phase == 1) && w_valid;
      if (m_wen) m_wgt = w_data;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_beats = 0; wen_cnt = 0; end
        1: if (w_valid) begin
             m_beats++;
             if (m_beats == ROWS) m_phase = 2;
           end
        2: if (a_valid && a_last) begin m_phase = 3; m_fl = 0; end
        default: if (m_fl == FLN - 1) m_phase = 0; else m_fl++;
      endcase
    end
    ring[(cyc + 1) & 15] = nv;
    cyc++;
  end

  function automatic logic [AW-1:0] rnd_a();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[AW-1:0];
  endfunction

  function automatic logic [WW-1:0] rnd_w();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[WW-1:0];
  endfunction

  logic [WW-1:0] wb [4];

  task automatic clk1();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; clk1(); start = 1'b0;
  endtask

  // Four weight beats; optional fixed gap before beat gap_at, or random gaps.
  task automatic load_w(input int gap_at, input int gap_len, input bit rnd_gaps);
    for (int b = 0; b < ROWS; b++) begin
      int g;
      g = (b == gap_at) ? gap_len : (rnd_gaps ? int'($urandom_range(0, 2)) : 0);
      repeat (g) begin w_valid = 1'b0; w_data = rnd_w(); clk1(); end
      w_valid = 1'b1; w_data = wb[b]; clk1();
    end
    w_valid = 1'b0;
  endtask

  // mode 0: no bubbles, 1: every third slot a bubble, 2: random bubbles.
  task automatic send_acts(input int n, input int mode, input bit noise, input bit with_last);
    int slot;
    slot = 0;
    for (int i = 0; i < n; i++) begin
      while ((mode == 1) ? (slot % 3 == 2) : (mode == 2 && $urandom_range(0, 3) == 0)) begin
        a_valid = 1'b0; a_last = 1'($urandom); a_data = rnd_a();
        start = noise ? 1'($urandom) : 1'b0;
        clk1(); slot++;
      end
      a_valid = 1'b1; a_data = rnd_a(); a_last = with_last && (i == n - 1);
      start = noise ? 1'($urandom) : 1'b0;
      clk1(); slot++;
    end
    a_valid = 1'b0; a_last = 1'b0; start = 1'b0;
  endtask

  // Called in the first FLUSH cycle; returns cycles advanced until done.
  task automatic wait_done(input bit noise, output int ncyc);
    bit seen;
    seen = 1'b0; ncyc = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1; start = 1'b0;
        chk("wen_pulses", wen_cnt, ROWS);
      end else begin
        start = noise ? 1'($urandom) : 1'b0;
        clk1(); ncyc++;
      end
    end
    chk("done_seen", seen, 1'b1);
    start = 1'b0;
    clk1();
  endtask

  initial begin
    int n;
    repeat (3) clk1();
    rst = 1'b0;
    clk1();
    chk("rst_busy", busy, 1'b0);
    chk("rst_active", active_left, '0);

    // Directed weights, then a single skew-check vector with a_last.
    wb[0] = {19'h2, 19'h1}; wb[1] = {19'h4, 19'h3};
    wb[2] = {19'h6, 19'h5}; wb[3] = {19'h8, 19'h7};
    pulse_start();
    load_w(-1, 0, 1'b0);
    a_valid = 1'b1; a_last = 1'b1;
    a_data = {19'h44, 19'h33, 19'h22, 19'h11};
    clk1();
    a_valid = 1'b0; a_last = 1'b0;
    wait_done(1'b1, n);
    chk("flush_len_a", n, FLN - 1);

    // Weight bubble between beats 2 and 3, then 6 vectors with periodic bubbles.
    for (int b = 0; b < ROWS; b++) wb[b] = rnd_w();
    pulse_start();
    load_w(2, 2, 1'b0);
    send_acts(6, 1, 1'b1, 1'b1);
    wait_done(1'b1, n);
    chk("flush_len_b", n, FLN - 1);

    // Random tiles with random gaps, bubbles and stray start pulses.
    repeat (8) begin
      for (int b = 0; b < ROWS; b++) wb[b] = rnd_w();
      pulse_start();
      load_w(-1, 0, 1'b1);
      send_acts(int'($urandom_range(1, 8)), 2, 1'b1, 1'b1);
      wait_done(1'b1, n);
      chk("flush_len_r", n, FLN - 1);
    end

    // Reset held 3 cycles in the middle of COMPUTE.
    for (int b = 0; b < ROWS; b++) wb[b] = rnd_w();
    pulse_start();
    load_w(-1, 0, 1'b0);
    send_acts(3, 0, 1'b0, 1'b0);
    a_valid = 1'b1; a_data = rnd_a(); rst = 1'b1;
    repeat (3) clk1();
    rst = 1'b0; a_valid = 1'b0;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_active", active_left, '0);
    chk("rst_mid_wcomp", w_compute, 1'b0);
    clk1();

    // Fresh tile after the mid-operation reset.
    pulse_start();
    load_w(-1, 0, 1'b1);
    send_acts(2, 0, 1'b0, 1'b1);
    wait_done(1'b0, n);
    chk("flush_len_post", n, FLN - 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
